// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU opcode encoding, sequencer
// state encoding and small opcode classification helpers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_LD  = 3'd6,
        OP_ST  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    // ADD/SUB are the only ops that consume and produce the carry flag.
    function automatic logic is_arith(alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by the execute sequencer.
// Ports:
//   CE            - enable; outputs are forced to zero when low
//   OP_CODE       - alu_op_t encoding
//   left_operand  - accumulator side
//   right_operand - operand / immediate
//   carry_in      - carry (ADD) or borrow (SUB) in
//   op_out        - SIZE-bit result
//   carry_out     - bit SIZE of the extended result (carry / borrow)
module alu
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            CE,
    input  logic [2:0]      OP_CODE,
    input  logic [SIZE-1:0] left_operand,
    input  logic [SIZE-1:0] right_operand,
    input  logic            carry_in,
    output logic [SIZE-1:0] op_out,
    output logic            carry_out
);

    logic [SIZE:0] wide;
    logic [SIZE:0] l_ext;
    logic [SIZE:0] r_ext;
    logic [SIZE:0] c_ext;

    assign l_ext = {1'b0, left_operand};
    assign r_ext = {1'b0, right_operand};
    assign c_ext = {{SIZE{1'b0}}, carry_in};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        wide = '0;
        case (alu_op_t'(OP_CODE))
            OP_ADD:  wide = l_ext + r_ext + c_ext;
            OP_SUB:  wide = l_ext - r_ext - c_ext;
            OP_AND:  wide = {1'b0, left_operand & right_operand};
            OP_OR:   wide = {1'b0, left_operand | right_operand};
            OP_XOR:  wide = {1'b0, left_operand ^ right_operand};
            OP_NOT:  wide = {1'b0, ~left_operand};
            OP_LD:   wide = r_ext;
            OP_ST:   wide = l_ext;
            default: wide = '0;
        endcase
        if (!CE) begin
            wide = '0;
        end
    end

    assign op_out    = wide[SIZE-1:0];
    assign carry_out = wide[SIZE];

endmodule

// File: rtl/alu_exec_sequencer_flag_reg.sv
// Architectural state of the execute stage: accumulator, carry and zero
// flags, each with its own write enable so the sequencer can apply the
// per-opcode update rules.
// Ports:
//   CLK, RST    - clock, asynchronous active-high reset (clears all state)
//   acc_we      - load acc from result
//   carry_we    - load carry_flag from carry_next
//   zero_we     - load zero_flag from (result == 0)
//   result      - captured ALU result
//   carry_next  - captured ALU carry out
//   acc, carry_flag, zero_flag - registered state
module alu_flag_reg #(
    parameter int SIZE = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            acc_we,
    input  logic            carry_we,
    input  logic            zero_we,
    input  logic [SIZE-1:0] result,
    input  logic            carry_next,
    output logic [SIZE-1:0] acc,
    output logic            carry_flag,
    output logic            zero_flag
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc        <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            if (acc_we)   acc        <= result;
            if (carry_we) carry_flag <= carry_next;
            if (zero_we)  zero_flag  <= (result == '0);
        end
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer in front of a combinational ALU. Accepts one
// instruction per handshake, drives the ALU for exactly one EXEC cycle,
// captures the result on the edge leaving EXEC, and retires in WB (stalling
// there for ST until the store sink accepts).
// Ports:
//   CLK, RST            - clock, asynchronous active-high reset
//   instr_valid/ready   - instruction handshake (ready only in IDLE)
//   instr_op            - alu_op_t opcode
//   instr_operand       - right operand / immediate
//   instr_use_carry     - ADD/SUB take carry_flag as carry_in
//   CE, OP_CODE, left_operand, right_operand, carry_in - ALU drive
//   op_out, carry_out   - ALU result
//   acc, carry_flag, zero_flag - architectural state
//   st_valid/ready/data - store port
//   done                - one pulse per retired instruction
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      instr_op,
    input  logic [SIZE-1:0] instr_operand,
    input  logic            instr_use_carry,
    output logic            CE,
    output logic [2:0]      OP_CODE,
    output logic [SIZE-1:0] left_operand,
    output logic [SIZE-1:0] right_operand,
    output logic            carry_in,
    input  logic [SIZE-1:0] op_out,
    input  logic            carry_out,
    output logic [SIZE-1:0] acc,
    output logic            carry_flag,
    output logic            zero_flag,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [SIZE-1:0] st_data,
    output logic            done
);

    seq_state_t state;
    seq_state_t next_state;
    alu_op_t    op_q;
    logic       done_q;
    logic       handshake;
    logic       in_exec;
    logic       st_accept;

    assign instr_ready  = (state == IDLE) && !RST;
    assign handshake    = instr_valid && instr_ready;
    assign in_exec      = (state == EXEC);
    assign st_accept    = st_valid && st_ready;
    assign OP_CODE      = op_q;
    assign left_operand = acc;

    // The store retire pulse must coincide with the accept cycle, which
    // depends on st_ready in that same cycle, so it cannot come from a flop.
    assign done = done_q || st_accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      if (op_q != OP_ST || st_accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ALU drive and store port, all registered and loaded on the handshake
    // so EXEC sees stable values for its whole cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CE            <= 1'b0;
            op_q          <= OP_ADD;
            right_operand <= '0;
            carry_in      <= 1'b0;
            done_q        <= 1'b0;
            st_valid      <= 1'b0;
            st_data       <= '0;
        end else begin
            CE       <= handshake;
            // Flags only change on the edge leaving EXEC, so the value read
            // here is the one EXEC would see.
            carry_in <= handshake && is_arith(alu_op_t'(instr_op))
                        && instr_use_carry && carry_flag;
            if (handshake) begin
                op_q          <= alu_op_t'(instr_op);
                right_operand <= instr_operand;
            end
            done_q <= in_exec && (op_q != OP_ST);
            if (in_exec && op_q == OP_ST) begin
                st_data  <= op_out;
                st_valid <= 1'b1;
            end else if (st_accept) begin
                st_valid <= 1'b0;
            end
        end
    end

    alu_flag_reg #(.SIZE(SIZE)) u_flag_reg (
        .CLK        (CLK),
        .RST        (RST),
        .acc_we     (in_exec && op_q != OP_ST),
        .carry_we   (in_exec && is_arith(op_q)),
        .zero_we    (in_exec && op_q != OP_ST),
        .result     (op_out),
        .carry_next (carry_out),
        .acc        (acc),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench: sequencer plus the real ALU, a cycle-by-cycle
// behavioural model on the falling edge, directed scenarios with literal
// expectations, then randomized instructions and store back-pressure.
module tb_alu_exec_sequencer;
    import alu_pkg::*;

    localparam int SIZE = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      instr_op;
    logic [SIZE-1:0] instr_operand;
    logic            instr_use_carry;
    logic            CE;
    logic [2:0]      OP_CODE;
    logic [SIZE-1:0] left_operand;
    logic [SIZE-1:0] right_operand;
    logic            carry_in;
    logic [SIZE-1:0] op_out;
    logic            carry_out;
    logic [SIZE-1:0] acc;
    logic            carry_flag;
    logic            zero_flag;
    logic            st_valid;
    logic            st_ready;
    logic [SIZE-1:0] st_data;
    logic            done;

    logic            rnd_mode = 1'b0;
    logic            rnd_ready = 1'b1;
    logic            st_ready_fixed = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mon_hs = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    always @(posedge CLK) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end
    assign st_ready = rnd_mode ? rnd_ready : st_ready_fixed;

    alu_exec_sequencer #(.SIZE(SIZE)) dut (
        .CLK(CLK), .RST(RST),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_operand(instr_operand),
        .instr_use_carry(instr_use_carry),
        .CE(CE), .OP_CODE(OP_CODE), .left_operand(left_operand),
        .right_operand(right_operand), .carry_in(carry_in),
        .op_out(op_out), .carry_out(carry_out),
        .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .done(done)
    );

    alu #(.SIZE(SIZE)) u_alu (
        .CE(CE), .OP_CODE(OP_CODE), .left_operand(left_operand),
        .right_operand(right_operand), .carry_in(carry_in),
        .op_out(op_out), .carry_out(carry_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting, 1 = the single ALU cycle,
    // 2 = retire cycle(s). State results computed with plain arithmetic.
    int      m_acc, m_cf, m_zf, m_opd, m_cin, ph, s;
    alu_op_t m_op;

    initial begin
        m_acc = 0; m_cf = 0; m_zf = 0; ph = 0; m_opd = 0; m_cin = 0; m_op = OP_ADD;
    end

    always @(negedge CLK) begin
        if (RST) begin
            m_acc = 0; m_cf = 0; m_zf = 0; ph = 0;
            check("rst_ready", instr_ready, 0);
            check("rst_ce", CE, 0);
            check("rst_done", done, 0);
            check("rst_st_valid", st_valid, 0);
            check("rst_acc", acc, 0);
            check("rst_flags", {carry_flag, zero_flag}, 0);
        end else begin
            check("acc", acc, m_acc);
            check("carry_flag", carry_flag, m_cf);
            check("zero_flag", zero_flag, m_zf);
            case (ph)
                0: begin
                    check("idle_ready", instr_ready, 1);
                    check("idle_ce", CE, 0);
                    check("idle_done", done, 0);
                    check("idle_st_valid", st_valid, 0);
                    if (instr_valid) begin
                        m_op  = alu_op_t'(instr_op);
                        m_opd = int'(instr_operand);
                        m_cin = ((m_op == OP_ADD || m_op == OP_SUB) && instr_use_carry) ? m_cf : 0;
                        mon_hs++;
                        ph = 1;
                    end
                end
                1: begin
                    check("exec_ready", instr_ready, 0);
                    check("exec_ce", CE, 1);
                    check("exec_opcode", OP_CODE, m_op);
                    check("exec_left", left_operand, m_acc);
                    check("exec_right", right_operand, m_opd);
                    check("exec_carry_in", carry_in, m_cin);
                    check("exec_done", done, 0);
                    check("exec_st_valid", st_valid, 0);
                    case (m_op)
                        OP_ADD: begin s = m_acc + m_opd + m_cin; m_cf = int'(s > 255); m_acc = s % 256; end
                        OP_SUB: begin s = m_acc - m_opd - m_cin; m_cf = int'(s < 0); m_acc = (s + 256) % 256; end
                        OP_AND: m_acc = m_acc & m_opd;
                        OP_OR:  m_acc = m_acc | m_opd;
                        OP_XOR: m_acc = m_acc ^ m_opd;
                        OP_NOT: m_acc = 255 - m_acc;
                        OP_LD:  m_acc = m_opd;
                        default: ;
                    endcase
                    if (m_op != OP_ST) m_zf = int'(m_acc == 0);
                    ph = 2;
                end
                default: begin
                    check("wb_ready", instr_ready, 0);
                    check("wb_ce", CE, 0);
                    if (m_op == OP_ST) begin
                        check("wb_st_valid", st_valid, 1);
                        check("wb_st_data", st_data, m_acc);
                        check("wb_st_done", done, st_ready);
                        if (st_ready) ph = 0;
                    end else begin
                        check("wb_done", done, 1);
                        check("wb_st_valid", st_valid, 0);
                        ph = 0;
                    end
                end
            endcase
        end
    end

    // All driver tasks run in the posedge+1 region.
    task automatic issue(input alu_op_t op, input int opd, input bit uc, input bit keep, output int hs);
        bit got;
        got = 0;
        hs  = -1;
        instr_op        = op;
        instr_operand   = SIZE'(opd);
        instr_use_carry = uc;
        instr_valid     = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (instr_ready) begin
                got = 1;
                hs  = cyc;
            end
            @(posedge CLK);
            #1;
        end
        check("handshake_timeout", got, 1);
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && !instr_ready; i++) begin
            @(posedge CLK);
            #1;
        end
        check("idle_timeout", instr_ready, 1);
    endtask

    task automatic run(input alu_op_t op, input int opd, input bit uc);
        int hs;
        issue(op, opd, uc, 1'b0, hs);
        wait_idle();
    endtask

    initial begin
        int hs;
        int hs_list[4];
        int hs_before;

        RST = 1'b1;
        instr_valid = 1'b0;
        instr_op = 3'd0;
        instr_operand = '0;
        instr_use_carry = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_opcode", OP_CODE, OP_ADD);
        check("rst_right", right_operand, 0);
        check("rst_st_data", st_data, 0);
        check("rst_carry_in", carry_in, 0);
        RST = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1);

        // LD 0xF0, ADD 0x20 -> 0x10, carry set
        run(OP_LD, 8'hF0, 1'b0);
        run(OP_ADD, 8'h20, 1'b0);
        check("t1_acc", acc, 8'h10);
        check("t1_cf", carry_flag, 1);
        check("t1_zf", zero_flag, 0);

        // carry kept through LD, then consumed: 5 + 3 + 1
        run(OP_LD, 8'h05, 1'b0);
        check("t2_cf_after_ld", carry_flag, 1);
        run(OP_ADD, 8'h03, 1'b1);
        check("t2_acc", acc, 8'h09);
        check("t2_cf", carry_flag, 0);

        // wrap to zero sets carry, then AND keeps it
        run(OP_LD, 8'hFF, 1'b0);
        run(OP_ADD, 8'h01, 1'b0);
        check("t3_wrap_acc", acc, 8'h00);
        check("t3_wrap_cf", carry_flag, 1);
        run(OP_LD, 8'h0F, 1'b0);
        run(OP_AND, 8'hF0, 1'b0);
        check("t3_acc", acc, 8'h00);
        check("t3_zf", zero_flag, 1);
        check("t3_cf", carry_flag, 1);

        // store with three stalled cycles
        run(OP_LD, 8'hA5, 1'b0);
        st_ready_fixed = 1'b0;
        issue(OP_ST, 8'h00, 1'b0, 1'b0, hs);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t4_st_valid", st_valid, 1);
            check("t4_st_data", st_data, 8'hA5);
            check("t4_ready", instr_ready, 0);
            check("t4_no_done", done, 0);
            @(posedge CLK);
            #1;
        end
        check("t4_st_valid_last", st_valid, 1);
        st_ready_fixed = 1'b1;
        #1;
        check("t4_done", done, 1);
        @(posedge CLK);
        #1;
        check("t4_st_drop", st_valid, 0);
        check("t4_acc", acc, 8'hA5);
        check("t4_ready_after", instr_ready, 1);

        // four LDs with instr_valid held high
        hs_before = mon_hs;
        issue(OP_LD, 8'h11, 1'b0, 1'b1, hs_list[0]);
        issue(OP_LD, 8'h22, 1'b0, 1'b1, hs_list[1]);
        issue(OP_LD, 8'h33, 1'b0, 1'b1, hs_list[2]);
        issue(OP_LD, 8'h44, 1'b0, 1'b0, hs_list[3]);
        wait_idle();
        for (int i = 1; i < 4; i++) check("t5_spacing", hs_list[i] - hs_list[i-1], 3);
        check("t5_count", mon_hs - hs_before, 4);
        check("t5_acc", acc, 8'h44);

        // reset in the middle of EXEC
        run(OP_LD, 8'h7F, 1'b0);
        issue(OP_ADD, 8'h01, 1'b0, 1'b0, hs);
        check("t6_in_exec", CE, 1);
        RST = 1'b1;
        #1;
        check("t6_acc", acc, 0);
        check("t6_ce", CE, 0);
        check("t6_flags", {carry_flag, zero_flag}, 0);
        check("t6_done", done, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run(OP_LD, 8'h3C, 1'b0);
        run(OP_ADD, 8'h05, 1'b0);
        check("t6_post_acc", acc, 8'h41);
        run(OP_SUB, 8'h42, 1'b0);
        check("t6_sub_acc", acc, 8'hFF);
        check("t6_sub_borrow", carry_flag, 1);

        // randomized instructions with random store back-pressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue(alu_op_t'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), (n != 199) && ($urandom_range(0, 1) == 1), hs);
        end
        rnd_mode = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
